// File: rtl/camera_pkg.sv
// Shared types and parameter checks for the camera capture path.
package camera_pkg;

  typedef enum logic [1:0] {
    SYNC,
    WAIT_FRAME_START,
    ACTIVE
  } cam_state_e;

  function automatic bit params_legal(input int bpp, input int dec);
    return (bpp >= 1) && (bpp <= 4) && ((dec == 1) || (dec == 2) || (dec == 4));
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Gathers camera bytes into one pixel word, first byte in the MSBs.
// word/done are combinational so the final byte is folded in on the cycle it arrives.
module pixel_packer #(
  parameter int BYTES_PER_PIXEL = 2
) (
  input  logic                         pixel_clock_in,
  input  logic                         rst_in,
  input  logic [7:0]                   byte_in,
  input  logic                         strobe,
  input  logic                         clear,
  output logic [8*BYTES_PER_PIXEL-1:0] word,
  output logic                         done
);

  localparam int PW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

  logic [PW-1:0]                     phase;
  logic [BYTES_PER_PIXEL-1:0][7:0]   held;
  logic                              last;

  assign last = (phase == PW'(BYTES_PER_PIXEL - 1));
  assign done = strobe && !clear && last;

  always_comb begin
    word = held;
    for (int i = 0; i < BYTES_PER_PIXEL; i++)
      if (phase == PW'(BYTES_PER_PIXEL - 1 - i)) word[8*i +: 8] = byte_in;
  end

  always_ff @(posedge pixel_clock_in) begin
    if (rst_in) begin
      phase <= '0;
      held  <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (strobe) begin
      for (int i = 0; i < BYTES_PER_PIXEL; i++)
        if (phase == PW'(BYTES_PER_PIXEL - 1 - i)) held[i] <= byte_in;
      phase <= last ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/camera_capture.sv
// Camera DVP-style capture: frame/line tracking, pixel assembly, decimation and
// framing error detection. Partial first frame after reset is discarded.
module camera_capture
  import camera_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int H_MAX           = 320,
  parameter int V_MAX           = 240,
  parameter int DECIMATE        = 1
) (
  input  logic                         pixel_clock_in,
  input  logic                         rst_in,
  input  logic                         vsync_in,
  input  logic                         href_in,
  input  logic [7:0]                   pixel_data_in,
  output logic [8*BYTES_PER_PIXEL-1:0] pixel_data_out,
  output logic                         pixel_valid_out,
  output logic [$clog2(H_MAX)-1:0]     hcount_out,
  output logic [$clog2(V_MAX)-1:0]     vcount_out,
  output logic                         line_done_out,
  output logic                         frame_done_out,
  output logic                         frame_error_out
);

  localparam int HW  = $clog2(H_MAX);
  localparam int VW  = $clog2(V_MAX);
  localparam int CW  = $clog2(H_MAX + 1);
  localparam int LW  = $clog2(V_MAX + 1);
  localparam int DSH = $clog2(DECIMATE);

  if (!params_legal(BYTES_PER_PIXEL, DECIMATE)) begin : g_bad_params
    $error("camera_capture: BYTES_PER_PIXEL must be 1..4 and DECIMATE 1, 2 or 4");
  end

  cam_state_e                  state;
  logic                        href_q, partial;
  logic [CW-1:0]               col_cnt;
  logic [LW-1:0]               line_cnt;
  logic                        active, fall, line_ok, col_ok, keep;
  logic                        pk_strobe, pk_clear, pk_done;
  logic [8*BYTES_PER_PIXEL-1:0] pk_word;

  always_comb begin
    active    = (state == ACTIVE) && !vsync_in;
    fall      = active && href_q && !href_in;
    line_ok   = line_cnt < LW'(V_MAX);
    col_ok    = col_cnt < CW'(H_MAX);
    keep      = ((int'(col_cnt) % DECIMATE) == 0) && ((int'(line_cnt) % DECIMATE) == 0);
    pk_strobe = active && href_in && line_ok && col_ok;
    // vsync priority: any non-active cycle also throws away a half-built pixel
    pk_clear  = !active || fall;
  end

  pixel_packer #(.BYTES_PER_PIXEL(BYTES_PER_PIXEL)) u_packer (
    .pixel_clock_in (pixel_clock_in),
    .rst_in         (rst_in),
    .byte_in        (pixel_data_in),
    .strobe         (pk_strobe),
    .clear          (pk_clear),
    .word           (pk_word),
    .done           (pk_done)
  );

  always_ff @(posedge pixel_clock_in) begin
    if (rst_in) begin
      state           <= SYNC;
      href_q          <= 1'b0;
      partial         <= 1'b0;
      col_cnt         <= '0;
      line_cnt        <= '0;
      pixel_data_out  <= '0;
      pixel_valid_out <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      line_done_out   <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      pixel_valid_out <= 1'b0;
      line_done_out   <= 1'b0;
      frame_done_out  <= 1'b0;
      href_q          <= active && href_in;
      unique case (state)
        SYNC: if (vsync_in) state <= WAIT_FRAME_START;
        WAIT_FRAME_START: begin
          if (!vsync_in) begin
            state           <= ACTIVE;
            line_cnt        <= '0;
            col_cnt         <= '0;
            partial         <= 1'b0;
            frame_error_out <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vsync_in) begin
            state          <= WAIT_FRAME_START;
            frame_done_out <= 1'b1;
            partial        <= 1'b0;
          end else begin
            if (fall) begin
              line_done_out <= line_ok;
              if (line_ok) line_cnt <= line_cnt + 1'b1;
              col_cnt <= '0;
              partial <= 1'b0;
              if (partial) frame_error_out <= 1'b1;
            end
            // overflowing bytes or lines are dropped but flag the frame
            if (href_in && !(line_ok && col_ok)) frame_error_out <= 1'b1;
            if (pk_strobe) partial <= !pk_done;
            if (pk_done) begin
              col_cnt <= col_cnt + 1'b1;
              if (keep) begin
                pixel_valid_out <= 1'b1;
                pixel_data_out  <= pk_word;
                hcount_out      <= HW'(col_cnt >> DSH);
                vcount_out      <= VW'(line_cnt >> DSH);
              end
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Randomized capture bench: two instances (full-rate with small V_MAX, and 2x decimation)
// share one camera stream and are compared per frame against a line/pixel list model.
module tb_camera_capture;

  localparam int BPP = 2;
  localparam int H   = 4;

  logic        clk = 1'b0;
  logic        rst, vsync, href;
  logic [7:0]  din;

  logic [15:0] data_a, data_b;
  logic        va, vb, lda, ldb, fda, fdb, era, erb;
  logic [1:0]  hca, vca, hcb, vcb;

  always #5 clk = ~clk;

  camera_capture #(.BYTES_PER_PIXEL(BPP), .H_MAX(H), .V_MAX(3), .DECIMATE(1)) dut_a (
    .pixel_clock_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href), .pixel_data_in(din),
    .pixel_data_out(data_a), .pixel_valid_out(va), .hcount_out(hca), .vcount_out(vca),
    .line_done_out(lda), .frame_done_out(fda), .frame_error_out(era));

  camera_capture #(.BYTES_PER_PIXEL(BPP), .H_MAX(H), .V_MAX(4), .DECIMATE(2)) dut_b (
    .pixel_clock_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href), .pixel_data_in(din),
    .pixel_data_out(data_b), .pixel_valid_out(vb), .hcount_out(hcb), .vcount_out(vcb),
    .line_done_out(ldb), .frame_done_out(fdb), .frame_error_out(erb));

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed strobes packed as {data, h, v}
  int obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  int ld_a = 0, ld_b = 0, fd_a = 0, fd_b = 0;

  always @(negedge clk) begin
    if (va) obs_a.push_back((int'(data_a) << 16) | (int'(hca) << 8) | int'(vca));
    if (vb) obs_b.push_back((int'(data_b) << 16) | (int'(hcb) << 8) | int'(vcb));
    ld_a += int'(lda); ld_b += int'(ldb);
    fd_a += int'(fda); fd_b += int'(fdb);
  end

  int         nl;
  int         lens[6];
  logic [7:0] bts[6][12];
  bit         abort_last;

  task automatic clear_obs();
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
    ld_a = 0; ld_b = 0; fd_a = 0; fd_b = 0;
  endtask

  task automatic gen_frame(input int n, input int fixed_len, input bit ab);
    nl = n; abort_last = ab;
    for (int l = 0; l < n; l++) begin
      lens[l] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 10));
      for (int k = 0; k < 12; k++) bts[l][k] = 8'($urandom);
    end
  endtask

  // Reference: every line is a byte list; pixels are byte pairs, clipped to H,
  // lines past V dropped, decimation keeps row/col multiples of d.
  task automatic model(input int which, input int v, input int d, output bit err, output int ld);
    int nlm, np, ent;
    nlm = abort_last ? nl - 1 : nl;
    err = 0; ld = 0;
    for (int l = 0; l < nlm; l++) begin
      if (l >= v) begin err = 1; continue; end
      ld++;
      if (lens[l] > BPP * H || (lens[l] % BPP) != 0) err = 1;
      np = (lens[l] / BPP > H) ? H : lens[l] / BPP;
      for (int c = 0; c < np; c++) begin
        if ((l % d) == 0 && (c % d) == 0) begin
          ent = (int'(bts[l][2*c]) << 24) | (int'(bts[l][2*c+1]) << 16) | ((c / d) << 8) | (l / d);
          if (which == 0) exp_a.push_back(ent); else exp_b.push_back(ent);
        end
      end
    end
  endtask

  task automatic drive_frame(input string tag);
    vsync = 1'b1; href = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, ".err_clr_a"}, era, 0);
    chk({tag, ".err_clr_b"}, erb, 0);
    for (int l = 0; l < nl; l++) begin
      bit stop;
      stop = 0;
      for (int k = 0; k < lens[l]; k++) begin
        @(negedge clk);
        href = 1'b1; din = bts[l][k];
        if (abort_last && l == nl - 1 && k == 1) begin vsync = 1'b1; stop = 1; break; end
      end
      @(negedge clk);
      href = 1'b0;
      if (stop) break;
      repeat (3) @(negedge clk);
    end
    vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input string tag);
    bit ea, eb;
    int la, lb;
    clear_obs();
    model(0, 3, 1, ea, la);
    model(1, 4, 2, eb, lb);
    drive_frame(tag);
    chk({tag, ".npix_a"}, obs_a.size(), exp_a.size());
    chk({tag, ".npix_b"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) chk({tag, ".pix_a"}, obs_a[i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) chk({tag, ".pix_b"}, obs_b[i], exp_b[i]);
    chk({tag, ".err_a"}, era, ea);
    chk({tag, ".err_b"}, erb, eb);
    chk({tag, ".ld_a"}, ld_a, la);
    chk({tag, ".ld_b"}, ld_b, lb);
    chk({tag, ".fd_a"}, fd_a, 1);
    chk({tag, ".fd_b"}, fd_b, 1);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst.valid", va, 0);
    chk("rst.ld", lda, 0);
    chk("rst.fd", fda, 0);
    chk("rst.err", era, 0);
    chk("rst.data", data_a, 0);
    chk("rst.h", hca, 0);
    chk("rst.v", vcb, 0);

    // vsync low out of reset: mid-frame, nothing captured
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); href = 1'b1; din = 8'($urandom); end
    @(negedge clk); href = 1'b0;
    repeat (3) @(negedge clk);
    chk("partial_first.npix", obs_a.size() + obs_b.size(), 0);
    chk("partial_first.ld", ld_a, 0);

    // reset mid-line aborts, following bytes without a vsync are ignored
    vsync = 1'b1; repeat (2) @(negedge clk); vsync = 1'b0; repeat (2) @(negedge clk);
    href = 1'b1; din = 8'h55;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); din = 8'($urandom); end
    @(negedge clk); href = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid.npix", obs_a.size() + obs_b.size(), 0);

    // directed A1 B2 C3 D4 line with latency checks
    clear_obs();
    vsync = 1'b1; repeat (3) @(negedge clk); vsync = 1'b0; repeat (2) @(negedge clk);
    href = 1'b1; din = 8'hA1;
    @(negedge clk); din = 8'hB2;
    chk("dir.early", va, 0);
    @(negedge clk); din = 8'hC3;
    chk("dir.v0", va, 1);
    chk("dir.d0", data_a, 16'hA1B2);
    chk("dir.h0", hca, 0);
    @(negedge clk); din = 8'hD4;
    chk("dir.gap", va, 0);
    @(negedge clk); href = 1'b0;
    chk("dir.v1", va, 1);
    chk("dir.d1", data_a, 16'hC3D4);
    chk("dir.h1", hca, 1);
    @(negedge clk);
    chk("dir.ld", lda, 1);
    @(negedge clk);
    chk("dir.ld_once", ld_a, 1);
    vsync = 1'b1; repeat (3) @(negedge clk);
    chk("dir.fd", fd_a, 1);

    gen_frame(4, 8, 0);  run_frame("dec4x4");
    chk("dec4x4.b_strobes", obs_b.size(), 4);
    gen_frame(1, 3, 0);  run_frame("odd_line");
    gen_frame(1, 12, 0); run_frame("hmax");
    gen_frame(3, 4, 1);  run_frame("vsync_abort");
    for (int f = 0; f < 10; f++) begin
      gen_frame(int'($urandom_range(1, 5)), 0, ($urandom_range(0, 3) == 0));
      run_frame($sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
